// File: rtl/servant_acc_dot.sv
// Dot-product accelerator: two operand buffers, LEN/CTRL/RES registers, 1 MAC per cycle.
// Optional SERVANT_ACC_IRQ_EN adds a level interrupt o_irq that mirrors the done flag.
module servant_acc_dot #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [10:0] i_wb_acc_adr,
    input  logic [31:0] i_wb_acc_dat,
    input  logic        i_wb_acc_we,
    output logic [31:0] o_wb_acc_rdt,
    output logic        o_busy
`ifdef SERVANT_ACC_IRQ_EN
    ,
    output logic        o_irq
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    localparam logic [9:0] LEN_MAX = 10'(DEPTH);

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_we_q;
    logic [9:0]         r_len;
    logic [63:0]        r_res;
    logic [63:0]        r_acc;
    logic [63:0]        r_prod;
    logic [AW-1:0]      r_idx;
    logic               r_v1;
    logic               r_v2;
    logic signed [31:0] r_a;
    logic signed [31:0] r_b;
    logic [31:0]        r_mem_a [DEPTH];
    logic [31:0]        r_mem_b [DEPTH];

    logic          w_sel_a;
    logic          w_sel_b;
    logic          w_sel_reg;
    logic [1:0]    w_reg;
    logic [AW-1:0] w_idx;
    logic          w_start;
    logic          w_clr;
    logic          w_len_wr;
    logic [9:0]    w_len_in;
    logic [63:0]   w_prod;

    assign w_sel_a   = (i_wb_acc_adr[10:9] == 2'b00);
    assign w_sel_b   = (i_wb_acc_adr[10:9] == 2'b01);
    assign w_sel_reg = (i_wb_acc_adr[10:2] == 9'h100);
    assign w_reg     = i_wb_acc_adr[1:0];
    assign w_idx     = i_wb_acc_adr[AW-1:0];

    // The strobe spans two edges per store; START must only fire on the first.
    assign w_start  = i_wb_acc_we & ~r_we_q & w_sel_reg & (w_reg == 2'd0) & i_wb_acc_dat[0];
    assign w_clr    = i_wb_acc_we & w_sel_reg & (w_reg == 2'd0) & i_wb_acc_dat[1];
    assign w_len_wr = i_wb_acc_we & w_sel_reg & (w_reg == 2'd1) & ~r_busy;
    assign w_len_in = (i_wb_acc_dat[9:0] > LEN_MAX) ? LEN_MAX : i_wb_acc_dat[9:0];
    assign w_prod   = r_a * r_b;

    assign o_busy = r_busy;
`ifdef SERVANT_ACC_IRQ_EN
    assign o_irq = r_done;
`endif

    always_ff @(posedge i_clk) begin
        if (i_wb_acc_we && !r_busy && w_sel_a) r_mem_a[w_idx] <= i_wb_acc_dat;
        if (i_wb_acc_we && !r_busy && w_sel_b) r_mem_b[w_idx] <= i_wb_acc_dat;
        r_a <= r_mem_a[r_idx];
        r_b <= r_mem_b[r_idx];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_acc_rdt <= 32'd0;
        end else if (w_sel_a) begin
            o_wb_acc_rdt <= r_busy ? 32'd0 : r_mem_a[w_idx];
        end else if (w_sel_b) begin
            o_wb_acc_rdt <= r_busy ? 32'd0 : r_mem_b[w_idx];
        end else if (w_sel_reg) begin
            case (w_reg)
                2'd0:    o_wb_acc_rdt <= {30'd0, r_done, r_busy};
                2'd1:    o_wb_acc_rdt <= {22'd0, r_len};
                2'd2:    o_wb_acc_rdt <= r_res[31:0];
                default: o_wb_acc_rdt <= r_res[63:32];
            endcase
        end else begin
            o_wb_acc_rdt <= 32'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we_q  <= 1'b0;
            r_len   <= 10'd0;
            r_res   <= 64'd0;
            r_acc   <= 64'd0;
            r_prod  <= 64'd0;
            r_idx   <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
        end else begin
            r_we_q <= i_wb_acc_we;
            r_v1   <= (r_state == StRun);
            r_v2   <= r_v1;
            r_prod <= w_prod;
            if (r_v2) r_acc <= r_acc + r_prod;
            if (w_len_wr) r_len <= w_len_in;
            if (w_clr) r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_acc <= 64'd0;
                        r_idx <= '0;
                        if (r_len == 10'd0) begin
                            r_done <= 1'b1;
                            r_res  <= 64'd0;
                        end else begin
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= StRun;
                        end
                    end
                end
                StRun: begin
                    r_idx <= r_idx + 1'b1;
                    if (10'(r_idx) == r_len - 10'd1) r_state <= StDrain;
                end
                default: begin
                    // Exit once the read and product stages have both emptied.
                    if (!r_v1 && !r_v2) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_res   <= r_acc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servant_acc_dot.sv
// Directed self-checking bench for servant_acc_dot: register map, runs, signed/wrap maths,
// busy-time write blocking, LEN clamping and mid-run reset.
module tb_servant_acc_dot;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [10:0] i_wb_acc_adr = '0;
    logic [31:0] i_wb_acc_dat = '0;
    logic        i_wb_acc_we = 1'b0;
    logic [31:0] o_wb_acc_rdt;
    logic        o_busy;
`ifdef SERVANT_ACC_IRQ_EN
    logic        o_irq;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [10:0] CTRL = 11'h400;
    localparam logic [10:0] LEN  = 11'h401;
    localparam logic [10:0] RLO  = 11'h402;
    localparam logic [10:0] RHI  = 11'h403;
    localparam logic [10:0] BB   = 11'h200;

    servant_acc_dot #(.DEPTH(256), .AW(8)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wb_acc_adr (i_wb_acc_adr),
        .i_wb_acc_dat (i_wb_acc_dat),
        .i_wb_acc_we  (i_wb_acc_we),
        .o_wb_acc_rdt (o_wb_acc_rdt),
        .o_busy       (o_busy)
`ifdef SERVANT_ACC_IRQ_EN
        ,
        .o_irq        (o_irq)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic [10:0] adr;
        logic [31:0] dat;
        logic [31:0] exp;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // CPU store: strobe high for two edges, then one idle edge.
    task automatic wr(input logic [10:0] a, input logic [31:0] d);
        i_wb_acc_adr = a;
        i_wb_acc_dat = d;
        i_wb_acc_we  = 1'b1;
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_wb_acc_we = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic rd(input logic [10:0] a, output logic [31:0] d);
        i_wb_acc_adr = a;
        i_wb_acc_we  = 1'b0;
        @(posedge i_clk);
        #1 d = o_wb_acc_rdt;
    endtask

    task automatic rd_check(input string name, input logic [10:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic apply(input vec_t v);
        if (v.we) wr(v.adr, v.dat);
        else rd_check(v.name, v.adr, v.exp);
    endtask

    // START and count the cycles o_busy is high, bounded.
    task automatic start_run(output int cycles);
        i_wb_acc_adr = CTRL;
        i_wb_acc_dat = 32'd1;
        i_wb_acc_we  = 1'b1;
        @(posedge i_clk);
        #1 cycles = o_busy ? 1 : 0;
        @(posedge i_clk);
        #1 i_wb_acc_we = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!o_busy) break;
            cycles++;
            @(posedge i_clk);
            #1;
        end
        @(posedge i_clk);
        #1;
    endtask

    vec_t basic_pre [15];
    vec_t basic_post[4];

    initial begin
        int          cyc;
        int          k;
        logic [31:0] d;

        basic_pre = '{
            '{1'b1, 11'h000,    32'd1, 32'd0, "wa0"},
            '{1'b1, 11'h001,    32'd2, 32'd0, "wa1"},
            '{1'b1, 11'h002,    32'd3, 32'd0, "wa2"},
            '{1'b1, 11'h003,    32'd4, 32'd0, "wa3"},
            '{1'b1, BB + 11'd0, 32'd5, 32'd0, "wb0"},
            '{1'b1, BB + 11'd1, 32'd6, 32'd0, "wb1"},
            '{1'b1, BB + 11'd2, 32'd7, 32'd0, "wb2"},
            '{1'b1, BB + 11'd3, 32'd8, 32'd0, "wb3"},
            '{1'b1, LEN,        32'd4, 32'd0, "wlen"},
            '{1'b0, 11'h102,    32'd0, 32'd3, "a_alias"},
            '{1'b0, BB + 11'd3, 32'd0, 32'd8, "b3_read"},
            '{1'b0, LEN,        32'd0, 32'd4, "len_read"},
            '{1'b1, 11'h404,    32'd9, 32'd0, "w_unmapped"},
            '{1'b0, 11'h404,    32'd0, 32'd0, "unmapped_read"},
            '{1'b0, 11'h7ff,    32'd0, 32'd0, "top_read"}
        };
        basic_post = '{
            '{1'b0, CTRL, 32'd0, 32'd2,  "basic_ctrl"},
            '{1'b0, RLO,  32'd0, 32'd70, "basic_res_lo"},
            '{1'b0, RHI,  32'd0, 32'd0,  "basic_res_hi"},
            '{1'b0, 11'h000, 32'd0, 32'd1, "a0_idle"}
        };

        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_rdt", o_wb_acc_rdt, 32'd0);
`ifdef SERVANT_ACC_IRQ_EN
        check("rst_irq", {31'd0, o_irq}, 32'd0);
`endif
        rd_check("rst_ctrl", CTRL, 32'd0);
        rd_check("rst_len", LEN, 32'd0);
        rd_check("rst_res_lo", RLO, 32'd0);
        rd_check("rst_res_hi", RHI, 32'd0);

        // Basic run: 1*5+2*6+3*7+4*8 = 70, busy LEN+3 cycles.
        for (int i = 0; i < 15; i++) apply(basic_pre[i]);
        start_run(cyc);
        check("basic_busy_cycles", cyc, 32'd7);
        for (int i = 0; i < 4; i++) apply(basic_post[i]);
`ifdef SERVANT_ACC_IRQ_EN
        check("irq_after_done", {31'd0, o_irq}, 32'd1);
        i_wb_acc_adr = CTRL;
        i_wb_acc_dat = 32'd2;
        i_wb_acc_we  = 1'b1;
        @(posedge i_clk);
        #1 check("irq_clr_same_edge", {31'd0, o_irq}, 32'd0);
        @(posedge i_clk);
        #1 i_wb_acc_we = 1'b0;
        @(posedge i_clk);
        #1;
        rd_check("ctrl_after_clr", CTRL, 32'd0);
`else
        wr(CTRL, 32'd2);
        rd_check("ctrl_after_clr", CTRL, 32'd0);
`endif

        // LEN=12 run with A[4..11]=B[4..11]=1 -> 70+8 = 78; mid-run accesses must be blocked.
        for (int i = 4; i < 12; i++) begin
            wr(11'(i), 32'd1);
            wr(BB + 11'(i), 32'd1);
        end
        wr(LEN, 32'd12);
        wr(CTRL, 32'd1);
        rd_check("run_ctrl", CTRL, 32'd1);
        rd_check("run_res_prev", RLO, 32'd70);
        wr(CTRL, 32'd1);
        wr(11'h000, 32'd100);
        wr(LEN, 32'd2);
        rd_check("run_buf_read_zero", 11'h001, 32'd0);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if (!o_busy) break;
            k++;
            @(posedge i_clk);
            #1;
        end
        check("single_run_tail", k, 32'd1);
        rd_check("mid_res_lo", RLO, 32'd78);
        rd_check("mid_res_hi", RHI, 32'd0);
        rd_check("mid_a0_unchanged", 11'h000, 32'd1);
        rd_check("mid_len_unchanged", LEN, 32'd12);
        rd_check("mid_ctrl_done", CTRL, 32'd2);

        // Signed: -3 * 7 = -21.
        wr(11'h000, 32'hFFFF_FFFD);
        wr(BB, 32'd7);
        wr(LEN, 32'd1);
        start_run(cyc);
        check("signed_busy_cycles", cyc, 32'd4);
        rd_check("signed_res_lo", RLO, 32'hFFFF_FFEB);
        rd_check("signed_res_hi", RHI, 32'hFFFF_FFFF);

        // LEN=0: done immediately, RES cleared, never busy.
        wr(LEN, 32'd0);
        start_run(cyc);
        check("len0_busy_cycles", cyc, 32'd0);
        rd_check("len0_ctrl", CTRL, 32'd2);
        rd_check("len0_res_lo", RLO, 32'd0);
        rd_check("len0_res_hi", RHI, 32'd0);

        wr(LEN, 32'd1000);
        rd_check("len_clamp", LEN, 32'd256);

        // 2 * (2^31)^2 = 2^63.
        wr(11'h000, 32'h8000_0000);
        wr(11'h001, 32'h8000_0000);
        wr(BB + 11'd0, 32'h8000_0000);
        wr(BB + 11'd1, 32'h8000_0000);
        wr(LEN, 32'd2);
        start_run(cyc);
        rd_check("wrap_res_lo", RLO, 32'd0);
        rd_check("wrap_res_hi", RHI, 32'h8000_0000);

        // Reset mid-run, then a fresh 4-entry run: 2^63 + 21 + 32.
        wr(LEN, 32'd4);
        wr(CTRL, 32'd1);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        check("mrst_busy", {31'd0, o_busy}, 32'd0);
        rd_check("mrst_ctrl", CTRL, 32'd0);
        rd_check("mrst_res_lo", RLO, 32'd0);
        rd_check("mrst_res_hi", RHI, 32'd0);
        rd_check("mrst_len", LEN, 32'd0);
        wr(LEN, 32'd4);
        wr(CTRL, 32'd3);
        rd_check("start_clr_ctrl", CTRL, 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (!o_busy) break;
            @(posedge i_clk);
            #1;
        end
        rd_check("post_rst_ctrl", CTRL, 32'd2);
        rd_check("post_rst_res_lo", RLO, 32'h0000_0035);
        rd_check("post_rst_res_hi", RHI, 32'h8000_0000);
`ifdef SERVANT_ACC_IRQ_EN
        check("irq_post_rst_run", {31'd0, o_irq}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/servant_acc_dot.md
Name: servant_acc_dot

Overview:
- Dot-product accelerator on the mux's accelerator slot (CPU address region 0x2000_0000–0x3FFF_FFFF).
- Consumes the word address, write data and qualified write strobe from the mux, and returns read data on the mux's accelerator read port.
- The CPU fills two operand buffers, writes a length and starts the engine. The engine does one signed 32x32 multiply-accumulate per cycle into a 64-bit result, which the CPU polls.

Parameters:
- DEPTH, 256, words per operand buffer; power of two, 2 to 512.
- AW, 8, buffer index width; must equal log2(DEPTH).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_wb_acc_adr  in  11  word address, CPU address bits [12:2]
- i_wb_acc_dat  in  32  write data
- i_wb_acc_we  in  1  write strobe, already qualified with cyc and slot select
- o_wb_acc_rdt  out  32  read data, registered
- o_busy  out  1  engine running, for debug/LED

Interface: reset i_rst, synchronous, active-high; clock i_clk.

Behaviour:
Address map (11-bit word address):
- 0x000..0x000+DEPTH-1: buffer A. Higher offsets below 0x200 alias, index = adr[AW-1:0].
- 0x200..0x200+DEPTH-1: buffer B, same aliasing.
- 0x400 CTRL
  - Write: bit0 = START, bit1 = CLR_DONE.
  - Read: {30'd0, done, busy}.
- 0x401 LEN: R/W, bits [9:0]. Written values above DEPTH are stored as DEPTH.
- 0x402 RES_LO: RO.
- 0x403 RES_HI: RO.
- Other addresses: writes ignored, reads return 0.

Read timing:
- o_wb_acc_rdt is registered from i_wb_acc_adr every cycle, giving 1-cycle latency. The mux acks one cycle after cyc, so data is valid at ack.

Write timing:
- The write strobe stays high for 2 consecutive edges per CPU store. All register and buffer writes are idempotent.
- START acts only on the first edge: we & ~we_q, with adr == 0x400 and dat[0] set.
- START while busy is ignored.

FSM:
- IDLE → RUN on START: clear accumulator, idx = 0, done = 0.
- RUN: issue sync read A[idx], B[idx]. The product is registered one stage later and accumulated one stage after that.
- RUN → DRAIN once idx == LEN-1 has been issued.
- DRAIN: 2 cycles to flush the pipeline, then → IDLE with done = 1 and RES latched.
- Total: START edge to done = LEN + 3 cycles.

LEN == 0:
- START goes straight to IDLE on the next edge, with done = 1 and RES = 0.

Arithmetic:
- Operands are signed two's complement; the 64-bit product is sign-extended.
- Accumulation wraps modulo 2^64, with no saturation.

While busy:
- Buffer writes ignored.
- Buffer reads return 0.
- LEN writes ignored.
- RES reads return the previous result; RES updates only at completion.

Done flag:
- Cleared by CLR_DONE or by a new START.
- If START and CLR_DONE are written together: the run starts and done = 0.

Reset values:
- o_wb_acc_rdt = 0, o_busy = 0, done = 0, LEN = 0, RES = 0, state IDLE.
- Buffer contents are undefined.
- Reset mid-run aborts immediately; RES reads 0 afterwards.

Optional Feature:
Macro: SERVANT_ACC_IRQ_EN
- Defined:
  - Adds output o_irq (1 bit, reset 0).
  - o_irq is a level signal: set in the cycle done rises, cleared by CLR_DONE, START or reset.
- Undefined:
  - Port o_irq absent.
  - Completion visible only via CTRL.done polling.
  - No other behaviour changes.

Test Plan:
- Basic run: A = {1,2,3,4}, B = {5,6,7,8}, LEN = 4, START → busy for 7 cycles, then done = 1, RES_LO = 70, RES_HI = 0.
- Signed: A[0] = 0xFFFFFFFD (-3), B[0] = 7, LEN = 1 → RES_HI = 0xFFFFFFFF, RES_LO = 0xFFFFFFEB.
- Strobe and busy handling:
  - START with we held 2 edges → exactly one run, done rises once.
  - Second START mid-run → ignored, RES unchanged from first run.
  - Buffer write mid-run → buffer unchanged.
- Boundaries:
  - LEN = 0 START → done next cycle, RES = 0.
  - Write LEN = 1000 → LEN reads DEPTH (256).
  - A = B = 0x80000000 × 2 entries → RES = 0x80000000_00000000 (wraps correctly).
- Reset: assert i_rst during RUN → o_busy = 0, done = 0, RES = 0. A new run afterwards produces the correct result.
- Macro on: o_irq rises with done. CLR_DONE write clears o_irq and done on the same edge.
